// File: rtl/sar_pkg.sv
// Shared state encoding and elaboration helpers for the SAR cycle sequencer.
package sar_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSample,
    StConv,
    StDone
  } sar_state_e;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    for (int i = 0; i < 32; i++) begin
      if ((32'd1 << i) < value) res = i + 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/sar_cycle_seq_if.sv
// Comparator-side inputs and result/flag outputs of the SAR cycle sequencer.
interface sar_cycle_seq_if #(
  parameter int unsigned Nbit = 10
);
  logic            cks;
  logic            rdy;
  logic            comp;
  logic [Nbit-1:0] cf;
  logic            final_flag;
  logic [Nbit-1:0] dout;
  logic            dvalid;
  logic            tmo;
  logic            abort;

  modport master (
    output cks, rdy, comp,
    input  cf, final_flag, dout, dvalid, tmo, abort
  );

  modport slave (
    input  cks, rdy, comp,
    output cf, final_flag, dout, dvalid, tmo, abort
  );
endinterface

// File: rtl/sar_sync.sv
// Multi-flop synchroniser for an asynchronous level with edge pulses taken
// from the synchronised copy.
module sar_sync #(
  parameter int unsigned Stages = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);
  logic [Stages-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[Stages-2:0], d_i};
      prev_q <= sync_q[Stages-1];
    end
  end

  assign q_o    = sync_q[Stages-1];
  assign rise_o = sync_q[Stages-1] & ~prev_q;
  assign fall_o = ~sync_q[Stages-1] & prev_q;
endmodule

// File: rtl/sar_cycle_seq.sv
// SAR conversion sequencer: tracks sample phase, collects MSB-first comparator
// decisions, drives per-cycle DAC flags and publishes the parallel result.
module sar_cycle_seq
  import sar_pkg::*;
#(
  parameter int unsigned Nbit       = 10,
  parameter int unsigned SyncStages = 2,
  parameter int unsigned TmoCyc     = 15,
  parameter bit          OneHot     = 1'b0
) (
  input logic            clk_i,
  input logic            rst_ni,
  sar_cycle_seq_if.slave bus
);
  localparam int unsigned      Kw     = clog2(Nbit + 1);
  localparam logic [Kw-1:0]    KLast  = Kw'(Nbit - 1);
  localparam logic [7:0]       TmoMax = 8'(TmoCyc);
  localparam logic [Nbit-1:0]  LsbOne = Nbit'(1);
  localparam logic [Nbit-1:0]  MsbOne = LsbOne << (Nbit - 1);

  logic cks_s, cks_rise, cks_fall, rdy_rise, comp_s;
  logic unused_rdy_lvl, unused_rdy_fall;
  logic [SyncStages-1:0] comp_sync_q;

  sar_sync #(.Stages(SyncStages)) u_cks_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (bus.cks),
    .q_o    (cks_s),
    .rise_o (cks_rise),
    .fall_o (cks_fall)
  );

  sar_sync #(.Stages(SyncStages)) u_rdy_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (bus.rdy),
    .q_o    (unused_rdy_lvl),
    .rise_o (rdy_rise),
    .fall_o (unused_rdy_fall)
  );

  // Same depth as RDY so COMP_s lines up with the detected RDY rise.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) comp_sync_q <= '0;
    else         comp_sync_q <= {comp_sync_q[SyncStages-2:0], bus.comp};
  end
  assign comp_s = comp_sync_q[SyncStages-1];

  sar_state_e      state_q, state_d;
  logic [Kw-1:0]   k_q, k_d;
  logic [7:0]      timer_q, timer_d;
  logic [Nbit-1:0] result_q, result_d, cf_q, cf_d, dout_q, dout_d;
  logic            final_q, final_d, dvalid_q, dvalid_d, tmo_q, tmo_d, abort_q, abort_d;
  logic            decide, bit_val;
  logic [Nbit-1:0] step_mask, bit_mask;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      k_q      <= '0;
      timer_q  <= '0;
      result_q <= '0;
      cf_q     <= '0;
      dout_q   <= '0;
      final_q  <= 1'b0;
      dvalid_q <= 1'b0;
      tmo_q    <= 1'b0;
      abort_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      timer_q  <= timer_d;
      result_q <= result_d;
      cf_q     <= cf_d;
      dout_q   <= dout_d;
      final_q  <= final_d;
      dvalid_q <= dvalid_d;
      tmo_q    <= tmo_d;
      abort_q  <= abort_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    timer_d   = timer_q;
    result_d  = result_q;
    cf_d      = cf_q;
    dout_d    = dout_q;
    final_d   = final_q;
    dvalid_d  = 1'b0;
    tmo_d     = tmo_q;
    abort_d   = 1'b0;
    decide    = 1'b0;
    bit_val   = 1'b0;
    step_mask = LsbOne << k_q;
    bit_mask  = MsbOne >> k_q;

    unique case (state_q)
      StIdle: begin
        if (cks_s) state_d = StSample;
      end
      StSample: begin
        cf_d     = '0;
        final_d  = 1'b0;
        tmo_d    = 1'b0;
        k_d      = '0;
        result_d = '0;
        timer_d  = '0;
        if (cks_fall) state_d = StConv;
      end
      StConv: begin
        if (cks_rise) begin
          state_d  = StSample;
          abort_d  = 1'b1;
          cf_d     = '0;
          final_d  = 1'b0;
          tmo_d    = 1'b0;
          k_d      = '0;
          result_d = '0;
          timer_d  = '0;
        end else if (rdy_rise) begin
          decide  = 1'b1;
          bit_val = comp_s;
        end else if (timer_q == TmoMax) begin
          // Forced decision resolves the bit to 0.
          decide = 1'b1;
          tmo_d  = 1'b1;
        end else begin
          timer_d = timer_q + 8'd1;
        end

        if (decide) begin
          timer_d = '0;
          k_d     = k_q + 1'b1;
          if (bit_val) result_d = result_q | bit_mask;
          cf_d = OneHot ? step_mask : (cf_q | step_mask);
          if (k_q == KLast) begin
            state_d  = StDone;
            dout_d   = result_d;
            dvalid_d = 1'b1;
            final_d  = 1'b1;
          end
        end
      end
      StDone: begin
        if (cks_rise) begin
          state_d = StSample;
          cf_d    = '0;
          final_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign bus.cf         = cf_q;
  assign bus.final_flag = final_q;
  assign bus.dout       = dout_q;
  assign bus.dvalid     = dvalid_q;
  assign bus.tmo        = tmo_q;
  assign bus.abort      = abort_q;
endmodule

// File: tb/tb_sar_cycle_seq.sv
// Directed-plus-random bench driving a thermometer and a one-hot sequencer
// from the same comparator stimulus.
module tb_sar_cycle_seq;
  localparam int unsigned Nbit = 10;

  logic clk = 1'b0;
  logic rst_n;
  logic cks, rdy, comp;
  int   checks = 0;
  int   errors = 0;
  int   dv_t = 0, dv_h = 0, ab_t = 0, ab_h = 0;

  always #5 clk = ~clk;

  sar_cycle_seq_if #(.Nbit(Nbit)) bus_t ();
  sar_cycle_seq_if #(.Nbit(Nbit)) bus_h ();

  assign bus_t.cks  = cks;
  assign bus_t.rdy  = rdy;
  assign bus_t.comp = comp;
  assign bus_h.cks  = cks;
  assign bus_h.rdy  = rdy;
  assign bus_h.comp = comp;

  sar_cycle_seq #(.Nbit(Nbit), .SyncStages(2), .TmoCyc(15), .OneHot(1'b0)) u_therm (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus_t)
  );

  sar_cycle_seq #(.Nbit(Nbit), .SyncStages(2), .TmoCyc(15), .OneHot(1'b1)) u_hot (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus_h)
  );

  always @(negedge clk) begin
    if (bus_t.dvalid === 1'b1) dv_t++;
    if (bus_h.dvalid === 1'b1) dv_h++;
    if (bus_t.abort === 1'b1) ab_t++;
    if (bus_h.abort === 1'b1) ab_h++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Flags after n decisions: thermometer fills from bit 0, one-hot marks the latest.
  function automatic logic [31:0] exp_cf(input bit hot, input int n);
    if (n == 0) return 32'd0;
    if (hot) return 32'd1 << (n - 1);
    return (32'd1 << n) - 32'd1;
  endfunction

  task automatic chk_cf(input string tag, input int n);
    chk({tag, "_cf_therm"}, 32'(bus_t.cf), exp_cf(1'b0, n));
    chk({tag, "_cf_onehot"}, 32'(bus_h.cf), exp_cf(1'b1, n));
  endtask

  task automatic chk_done(input string tag, input logic [Nbit-1:0] exp_dout, input logic exp_tmo,
                          input int exp_dv);
    chk({tag, "_dout_therm"}, 32'(bus_t.dout), 32'(exp_dout));
    chk({tag, "_dout_onehot"}, 32'(bus_h.dout), 32'(exp_dout));
    chk({tag, "_final_therm"}, 32'(bus_t.final_flag), 32'd1);
    chk({tag, "_final_onehot"}, 32'(bus_h.final_flag), 32'd1);
    chk({tag, "_tmo_therm"}, 32'(bus_t.tmo), 32'(exp_tmo));
    chk({tag, "_tmo_onehot"}, 32'(bus_h.tmo), 32'(exp_tmo));
    chk({tag, "_dvalid_cnt_therm"}, 32'(dv_t), 32'(exp_dv));
    chk({tag, "_dvalid_cnt_onehot"}, 32'(dv_h), 32'(exp_dv));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_cf"}, 32'(bus_t.cf), 32'd0);
    chk({tag, "_cf_h"}, 32'(bus_h.cf), 32'd0);
    chk({tag, "_dout"}, 32'(bus_t.dout), 32'd0);
    chk({tag, "_dout_h"}, 32'(bus_h.dout), 32'd0);
    chk({tag, "_final"}, 32'(bus_t.final_flag), 32'd0);
    chk({tag, "_final_h"}, 32'(bus_h.final_flag), 32'd0);
    chk({tag, "_tmo"}, 32'(bus_t.tmo), 32'd0);
    chk({tag, "_tmo_h"}, 32'(bus_h.tmo), 32'd0);
  endtask

  task automatic start_conv();
    @(negedge clk);
    cks = 1'b1;
    repeat (5) @(negedge clk);
    cks = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic rdy_pulse(input logic c);
    int unsigned hi, lo;
    hi   = $urandom_range(5, 3);
    lo   = $urandom_range(5, 3);
    comp = c;
    @(negedge clk);
    rdy = 1'b1;
    repeat (hi) @(negedge clk);
    rdy = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  initial begin
    logic [Nbit-1:0] pat, exp_dout;
    logic            b;
    int              dv_exp;

    rst_n = 1'b0;
    cks   = 1'b0;
    rdy   = 1'b0;
    comp  = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    chk("reset_dvalid", 32'(bus_t.dvalid), 32'd0);
    chk("reset_abort", 32'(bus_h.abort), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed conversion, COMP 1,0,1,1,0,0,1,0,1,1 MSB first.
    pat = 10'b1011001011;
    start_conv();
    chk_cf("sample", 0);
    exp_dout = '0;
    for (int i = 0; i < int'(Nbit); i++) begin
      b = pat[Nbit-1-i];
      rdy_pulse(b);
      exp_dout = {exp_dout[Nbit-2:0], b};
      chk_cf("dir", i + 1);
    end
    chk_done("dir", 10'h2CB, 1'b0, 1);

    // RDY edges after completion change nothing.
    repeat (3) rdy_pulse(1'b1);
    chk_cf("post_done", int'(Nbit));
    chk_done("post_done", 10'h2CB, 1'b0, 1);

    // Abort after four decisions.
    start_conv();
    for (int i = 0; i < 4; i++) rdy_pulse(1'($urandom_range(1, 0)));
    chk_cf("pre_abort", 4);
    @(negedge clk);
    cks = 1'b1;
    repeat (5) @(negedge clk);
    chk("abort_cnt_therm", 32'(ab_t), 32'd1);
    chk("abort_cnt_onehot", 32'(ab_h), 32'd1);
    chk_cf("abort", 0);
    chk("abort_dvalid_cnt", 32'(dv_t), 32'd1);
    chk("abort_dout", 32'(bus_t.dout), 32'h2CB);

    // Timeout: RDY withheld after three decisions forces bit 6 to 0.
    start_conv();
    for (int i = 0; i < 3; i++) rdy_pulse(1'b1);
    chk("pre_tmo_tmo", 32'(bus_t.tmo), 32'd0);
    repeat (18) @(negedge clk);
    chk_cf("tmo_forced", 4);
    chk("tmo_set_therm", 32'(bus_t.tmo), 32'd1);
    chk("tmo_set_onehot", 32'(bus_h.tmo), 32'd1);
    for (int i = 0; i < 6; i++) rdy_pulse(1'b1);
    chk_done("tmo", 10'h3BF, 1'b1, 2);

    // Random conversions against a shift-in model.
    dv_exp = 2;
    for (int c = 0; c < 3; c++) begin
      start_conv();
      exp_dout = '0;
      for (int i = 0; i < int'(Nbit); i++) begin
        b = 1'($urandom_range(1, 0));
        rdy_pulse(b);
        exp_dout = {exp_dout[Nbit-2:0], b};
      end
      dv_exp++;
      chk_cf("rnd", int'(Nbit));
      chk_done("rnd", exp_dout, 1'b0, dv_exp);
    end

    // Asynchronous reset mid-conversion, then a clean conversion.
    start_conv();
    for (int i = 0; i < 5; i++) rdy_pulse(1'($urandom_range(1, 0)));
    chk_cf("pre_rst", 5);
    #3 rst_n = 1'b0;
    #1;
    chk_zero("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    start_conv();
    exp_dout = '0;
    for (int i = 0; i < int'(Nbit); i++) begin
      b = 1'($urandom_range(1, 0));
      rdy_pulse(b);
      exp_dout = {exp_dout[Nbit-2:0], b};
    end
    dv_exp++;
    chk_cf("after_rst", int'(Nbit));
    chk_done("after_rst", exp_dout, 1'b0, dv_exp);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
